// File: rtl/ahb_port_pkg.sv
// Shared encodings for the AHB GPIO port: register map, HTRANS/HSIZE codes
// and the byte-lane decode used on writes.
package ahb_port_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    REG_OUT     = 2'd0,
    REG_IN      = 2'd1,
    REG_STATUS  = 2'd2,
    REG_CHGMASK = 2'd3
  } reg_sel_e;

  localparam logic [3:0] OFF_OUT     = 4'h0;
  localparam logic [3:0] OFF_IN      = 4'h4;
  localparam logic [3:0] OFF_STATUS  = 4'h8;
  localparam logic [3:0] OFF_CHGMASK = 4'hC;

  typedef struct packed {
    logic       valid;
    logic       write;
    reg_sel_e   sel;
    logic [2:0] size;
    logic [1:0] addr_lo;
  } dphase_t;

  // Misaligned halfwords and any size above word fall back to a full-word access.
  function automatic logic [31:0] lane_mask(logic [2:0] size, logic [1:0] addr_lo);
    logic [3:0]  lanes;
    logic [31:0] mask;
    lanes = 4'b1111;
    if (size == HSIZE_BYTE)
      lanes = 4'b0001 << addr_lo;
    else if (size == HSIZE_HALF && !addr_lo[0])
      lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
    for (int unsigned i = 0; i < 4; i++)
      mask[8*i +: 8] = {8{lanes[i]}};
    return mask;
  endfunction

endpackage

// File: rtl/ahb_port_if.sv
// AHB-Lite slave-side signal bundle for the GPIO port.
interface ahb_port_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_port_sync_bus.sv
// Multi-flop synchronizer for an asynchronous input bus.
module sync_bus #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/ahb_port.sv
// Zero-wait-state AHB GPIO port: OUT register to LEDs, synchronized IN with
// sticky change detection (STATUS/CHGMASK, write-1-to-clear).
module ahb_port
  import ahb_port_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  ahb_port_if.slave   bus,
  input  logic [31:0] iPort,
  output logic [31:0] oPort,
  output logic        DataValid
);

  localparam logic [3:0] FILL_MAX = 4'(SYNC_STAGES + 1);

  logic [31:0] in_sync, prev, out_reg, chg_mask;
  logic [31:0] bmask, wbits, diff, rdata;
  logic        chg, accept, armed;
  logic [3:0]  fill;
  dphase_t     dp;
  logic        unused_ok;

  sync_bus #(.WIDTH(32), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (HCLK),
    .rst_n(HRESETn),
    .d    (iPort),
    .q    (in_sync)
  );

  assign accept    = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign unused_ok = ^{bus.HADDR[31:4], bus.HTRANS[0]};

  // Compare stays off until reset zeros have flushed out of the synchronizer.
  assign armed = (fill == FILL_MAX);
  assign diff  = armed ? (in_sync ^ prev) : '0;

  always_comb begin
    bmask = '0;
    if (dp.valid && dp.write) bmask = lane_mask(dp.size, dp.addr_lo);
    wbits = bus.HWDATA & bmask;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp       <= '0;
      prev     <= '0;
      fill     <= '0;
      out_reg  <= '0;
      chg_mask <= '0;
      chg      <= 1'b0;
    end else begin
      dp.valid   <= accept;
      dp.write   <= bus.HWRITE;
      dp.sel     <= reg_sel_e'(bus.HADDR[3:2]);
      dp.size    <= bus.HSIZE;
      dp.addr_lo <= bus.HADDR[1:0];
      prev       <= in_sync;
      if (!armed) fill <= fill + 4'd1;

      if (dp.sel == REG_OUT) out_reg <= (out_reg & ~bmask) | wbits;
      // New changes are OR-ed in after the clear so a coincident set wins.
      chg_mask <= diff | (chg_mask & ~((dp.sel == REG_CHGMASK) ? wbits : '0));
      chg      <= (|diff) | (chg & ~((dp.sel == REG_STATUS) & wbits[0]));
    end
  end

  always_comb begin
    rdata = '0;
    if (dp.valid && !dp.write) begin
      case (dp.sel)
        REG_OUT:     rdata = out_reg;
        REG_IN:      rdata = in_sync;
        REG_STATUS:  rdata = {31'b0, chg};
        REG_CHGMASK: rdata = chg_mask;
        default:     rdata = '0;
      endcase
    end
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;
  assign oPort         = out_reg;
  assign DataValid     = (out_reg != '1);

endmodule

// File: doc/ahb_port.md
AHB_PORT -- requirements
Module: ahb_port

Interface
REQ-001 The block SHALL use one clock and one reset: clock HCLK, reset HRESETn; reset is asynchronous and active-low.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on iPort (legal 2..3).
REQ-003 HCLK  input  1  system clock, rising edge.
REQ-004 HRESETn  input  1  asynchronous active-low reset.
REQ-005 HSEL  input  1  slave select (address phase).
REQ-006 HADDR  input  32  byte address; only [3:0] decoded.
REQ-007 HTRANS  input  2  transfer type; NONSEQ/SEQ = active, IDLE/BUSY = no transfer.
REQ-008 HWRITE  input  1  1 = write, 0 = read.
REQ-009 HSIZE  input  3  0 = byte, 1 = halfword, 2 = word.
REQ-010 HWDATA  input  32  write data (data phase).
REQ-011 HREADY  input  1  bus ready; address phase sampled only when high.
REQ-012 HRDATA  output  32  read data (data phase).
REQ-013 HREADYOUT  output  1  slave ready; constant 1 (zero wait states).
REQ-014 HRESP  output  1  constant 0 (OKAY).
REQ-015 iPort  input  32  asynchronous external inputs (switches/keys).
REQ-016 oPort  output  32  registered external outputs (LEDs).
REQ-017 DataValid  output  1  high when oPort != 32'hFFFF_FFFF.

Function
REQ-018 Address phase SHALL be accepted when HSEL & HREADY & HTRANS[1]; HADDR[3:2], HWRITE, HSIZE, HADDR[1:0] captured into data-phase registers that cycle.
REQ-019 Register map: 0x0 OUT (RW, drives oPort), 0x4 IN (RO, synchronized iPort), 0x8 STATUS (bit0 CHG sticky, W1C; bits 31:1 read 0), 0xC CHGMASK (RO bits changed since last clear, W1C).
REQ-020 Writes SHALL commit at the HCLK edge ending the data phase, using byte lanes from captured HSIZE/HADDR[1:0]; unaddressed lanes unchanged.
REQ-021 Writes to IN SHALL be ignored; W1C writes to STATUS/CHGMASK clear only bits written 1 within enabled lanes.
REQ-022 HRDATA SHALL present the selected register during a read data phase, and 0 otherwise; read of a register written in the immediately preceding transfer returns the new value.
REQ-023 iPort SHALL pass through SYNC_STAGES flops; IN = last stage; one further register holds the previous sample.
REQ-024 Each cycle, CHGMASK |= (IN ^ previous); CHG set when that XOR is nonzero.
REQ-025 Simultaneous set and W1C clear on the same bit: set SHALL win.
REQ-026 iPort change visible in IN exactly SYNC_STAGES cycles later; CHG/CHGMASK set one cycle after IN changes.
REQ-027 IDLE/BUSY transfers, HSEL low, or HREADY low SHALL cause no register change.
REQ-028 Misaligned or oversize HSIZE (>2) SHALL be treated as word access; still OKAY.

Reset
REQ-029 On HRESETn low: OUT = 0 (oPort = 0, DataValid = 1), synchronizers, previous sample, CHG, CHGMASK = 0, data-phase valid = 0, HRDATA = 0.
REQ-030 Reset mid-transfer SHALL abandon the pending data phase; no write commits.
REQ-031 First cycle after reset release SHALL not flag a change from reset-value synchronizers (previous-sample compare disabled until pipeline filled, SYNC_STAGES+1 cycles).

Structure
REQ-032 Package ahb_port_pkg SHALL hold register offsets, HTRANS encodings, and HSIZE encodings.
REQ-033 Sub-module sync_bus (parameterised width/stages, async active-low reset) SHALL implement the iPort synchronizer.

Verification
REQ-034 Reset, read 0x0/0x8/0xC -> 0, 0, 0; oPort = 0, DataValid = 1.
REQ-035 Word write 0xFFFF_FFFF to 0x0, then byte write 0x00 to 0x1 -> oPort 0xFFFF_00FF; DataValid 0 after first write, 1 after second.
REQ-036 iPort 0x000 -> 0x205 -> read 0x4 after 3 cycles = 0x205; 0x8 = 1; 0xC = 0x205.
REQ-037 Write 0x004 to 0xC while iPort bit2 toggles same cycle -> CHGMASK bit2 stays 1; write 0x201 -> CHGMASK 0x004.
REQ-038 Back-to-back write 0xA5 to 0x0 then read 0x0 (pipelined, no idle) -> HRDATA 0xA5; HREADYOUT 1 and HRESP 0 throughout.
REQ-039 Assert HRESETn low during write data phase to 0x0 -> oPort 0 after reset, no commit of write data.
